dmem_master: RTL and testbench

// - Initiator side of the data-memory port: the processor core issues load/store requests on a

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_master.sv | 125 ++++++++++++
 tb/tb_dmem_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory master: FSM state encoding and
// default widths used by the block and its surroundings.
package dmem_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 16;
   localparam int LEN_W_DEF   = 4;
   localparam int RD_WAIT_DEF = 1;

endpackage

// File: rtl/dmem_master.sv
// Initiator side of the data-memory port. Accepts single-word stores and
// burst loads from the core, drives the Data_Memory strobes and returns
// loaded words one at a time on a response handshake.
//
// Handshake rules: a request transfers on a clock edge where req_valid and
// req_ready are both high; req_ready is only high in IDLE, so a requester
// must hold req_valid until it sees the transfer. A response word transfers
// on an edge where rsp_valid and rsp_ready are both high; rsp_valid, rsp_data
// and rsp_last are held unchanged until that edge.
module dmem_master
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int RD_WAIT = RD_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);

   state_t             state;
   logic [WAIT_W-1:0]  wait_cnt;   // cycles mem_rd has been held for the current word
   logic [LEN_W-1:0]   beat_cnt;   // index of the word currently being fetched
   logic [LEN_W-1:0]   len_q;      // latched burst length (words minus one)

   // Control FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data  <= '0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
         beat_cnt  <= '0;
         len_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  mem_addr  <= req_addr;
                  wait_cnt  <= '0;
                  beat_cnt  <= '0;
                  if (req_write) begin
                     mem_wdata <= req_wdata;
                     mem_wr    <= 1'b1;
                     state     <= ST_WRITE;
                  end else begin
                     len_q  <= req_len;
                     mem_rd <= 1'b1;
                     state  <= ST_READ;
                  end
               end
            end

            // Store strobe lasts exactly one cycle.
            ST_WRITE: begin
               mem_wr    <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end

            // Hold mem_rd for RD_WAIT cycles, sample R_data on the last edge.
            ST_READ: begin
               if (wait_cnt == WAIT_LAST) begin
                  rsp_data  <= mem_rdata;
                  rsp_valid <= 1'b1;
                  rsp_last  <= (beat_cnt == len_q);
                  mem_rd    <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            // Present the word; no memory access starts until it is taken.
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  if (rsp_last) begin
                     req_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                     mem_addr <= mem_addr + 1'b1;  // wraps modulo 2**ADDR_W
                     mem_rd   <= 1'b1;
                     state    <= ST_READ;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: a Data_Memory model, a request driver, a response
// consumer and a negedge monitor comparing DUT activity against expectations
// produced by a word-level reference memory at request acceptance.
module tb_dmem_master;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int LEN_W   = 4;
   localparam int RD_WAIT = 1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              first;
      int                acc;
   } rsp_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                acc;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [LEN_W-1:0]  req_len = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] tb_mem  [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

   rsp_t              rsp_q[$];
   wr_t               wr_q[$];
   logic [ADDR_W-1:0] rd_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic hold_low = 1'b0;
   logic rand_mode = 1'b0;

   dmem_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_WAIT(RD_WAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Data_Memory model: combinational read, write on the clock edge
   assign mem_rdata = tb_mem[mem_addr];
   initial begin
      for (int i = 0; i < (1<<ADDR_W); i++) tb_mem[i] = DATA_W'($urandom);
      tb_mem[0] = 16'h0003;
      tb_mem[1] = 16'h000C;
      forever begin
         @(posedge clk);
         if (mem_wr) tb_mem[mem_addr] = mem_wdata;
      end
   end

   // response consumer
   initial forever begin
      @(posedge clk);
      #1;
      if (hold_low) rsp_ready = 1'b0;
      else if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver: offer a request, hold it until accepted, then push expectations
   task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
      int acc;
      bit ok;
      ok = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_wdata = d;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("req_accept_timeout", 32'd0, 32'd1);
      end else begin
         acc = cyc + 1;
         chk("busy_accept_outstanding", rsp_q.size() + wr_q.size() + rd_q.size(), 0);
         if (w) begin
            wr_q.push_back('{a, d, acc});
            ref_mem[a] = d;
         end else begin
            for (int i = 0; i <= int'(l); i++) begin
               rsp_q.push_back('{ref_mem[ADDR_W'(int'(a) + i)], (i == int'(l)), (i == 0), acc});
               rd_q.push_back(ADDR_W'(int'(a) + i));
            end
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = ADDR_W'($urandom);
      req_len   = LEN_W'($urandom);
      req_wdata = DATA_W'($urandom);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (rsp_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0 && req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // monitor / scoreboard
   logic              prev_rd = 1'b0;
   logic              prev_valid = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_rd = 1'b0;
         prev_valid = 1'b0;
      end else begin
         rsp_t e;
         if (mem_rd || mem_wr) chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
         if (rsp_valid) chk("no_rd_while_rsp", {31'd0, mem_rd}, 32'd0);
         if (mem_rd && prev_rd) chk("rd_addr_stable", 32'(mem_addr), 32'(prev_addr));
         if (mem_rd && !prev_rd) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
         end
         if (mem_wr) begin
            if (wr_q.size() == 0) begin
               chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(w.addr));
               chk("wr_data", 32'(mem_wdata), 32'(w.data));
               chk("wr_latency", 32'(cyc - w.acc), 32'd0);
            end
         end
         if (rsp_valid && !prev_valid && rsp_q.size() > 0 && rsp_q[0].first)
            chk("rsp_first_latency", 32'(cyc - rsp_q[0].acc), 32'(RD_WAIT));
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = rsp_q.pop_front();
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
            end
         end
         prev_rd = mem_rd;
         prev_valid = rsp_valid;
         prev_addr = mem_addr;
      end
   end

   // main sequence
   initial begin
      logic [ADDR_W-1:0] a0;
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      ref_mem = tb_mem;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // store then load back
      issue(1'b1, 8'h05, 4'd0, 16'h00AB);
      issue(1'b0, 8'h05, 4'd0, 16'h0000);
      wait_idle();

      // two-word burst from the preloaded words
      issue(1'b0, 8'h00, 4'd1, 16'h0000);
      wait_idle();

      // burst across the address wrap
      issue(1'b0, 8'hFE, 4'd2, 16'h0000);
      wait_idle();

      // stall the first word for three cycles
      hold_low = 1'b1;
      issue(1'b0, 8'h00, 4'd1, 16'h0000);
      seen = 0;
      for (int t = 0; t < 50; t++) begin
         if (rsp_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         chk("stall_rsp_timeout", 32'd0, 32'd1);
      end else begin
         a0 = mem_addr;
         for (int k = 0; k < 3; k++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(rsp_q[0].data));
            chk("stall_mem_rd", {31'd0, mem_rd}, 32'd0);
            chk("stall_addr", 32'(mem_addr), 32'(a0));
            @(negedge clk);
         end
      end
      hold_low = 1'b0;
      wait_idle();

      // store offered while a burst runs
      issue(1'b0, 8'h10, 4'd3, 16'h0000);
      issue(1'b1, 8'h20, 4'd0, 16'h1234);
      issue(1'b0, 8'h20, 4'd0, 16'h0000);
      wait_idle();

      // reset in the middle of a long burst
      issue(1'b0, ADDR_W'($urandom), 4'd15, 16'h0000);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rsp_q.delete();
      rd_q.delete();
      wr_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
         chk("postrst_quiet", {30'd0, rsp_valid, mem_rd}, 32'd0);
      end

      // randomized traffic with a random consumer
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         issue(1'($urandom), ADDR_W'($urandom), LEN_W'($urandom), DATA_W'($urandom));
      end
      wait_idle();
      rand_mode = 1'b0;

      chk("final_rsp_q_empty", rsp_q.size(), 0);
      chk("final_wr_q_empty", wr_q.size(), 0);
      chk("final_rd_q_empty", rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // overall time limit
   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1);
   end

endmodule
